// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between the issue logic (master) and the ALU sequencer (slave).
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;

    modport master (
        output req_valid, req_funct, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_funct, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front end for TotalALU: takes one operation at a time, sequences MULTU as multiply + MFHI + MFLO,
// and returns each result word over a valid/ready response channel.
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 35
) (
    input  logic        clk,
    input  logic        reset,
    alu_op_sequencer_if.slave bus,
    output logic        busy,
    output logic        alu_reset,
    output logic [5:0]  alu_signal,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    input  logic [31:0] alu_output
);

    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, EXEC, MUL_WAIT, MFHI, RSP_HI, MFLO, RSP
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  funct_q, funct_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_err_q, rsp_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            funct_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct_q    <= funct_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // The ALU idles on AND with zero operands so signal 25 is only ever seen while multiplying.
    always_comb begin
        state_d     = state_q;
        funct_d     = funct_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        alu_signal  = FN_AND;
        alu_dataA   = '0;
        alu_dataB   = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    funct_d = bus.req_funct;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    case (bus.req_funct)
                        FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SLL: state_d = EXEC;
                        FN_MULTU: begin
                            state_d = MUL_WAIT;
                            cnt_d   = MUL_LOAD;
                        end
                        default: begin
                            state_d    = RSP;
                            rsp_data_d = '0;
                            rsp_err_d  = 1'b1;
                            rsp_last_d = 1'b1;
                        end
                    endcase
                end
            end
            EXEC: begin
                alu_signal = funct_q;
                alu_dataA  = a_q;
                alu_dataB  = b_q;
                rsp_data_d = alu_output;
                rsp_last_d = 1'b1;
                rsp_err_d  = 1'b0;
                state_d    = RSP;
            end
            MUL_WAIT: begin
                alu_signal = FN_MULTU;
                alu_dataA  = a_q;
                alu_dataB  = b_q;
                if (cnt_q == '0) begin
                    state_d = MFHI;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            MFHI: begin
                alu_signal = FN_MFHI;
                rsp_data_d = alu_output;
                rsp_last_d = 1'b0;
                rsp_err_d  = 1'b0;
                state_d    = RSP_HI;
            end
            RSP_HI: begin
                if (bus.rsp_ready) state_d = MFLO;
            end
            MFLO: begin
                alu_signal = FN_MFLO;
                rsp_data_d = alu_output;
                rsp_last_d = 1'b1;
                rsp_err_d  = 1'b0;
                state_d    = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RSP_HI) || (state_q == RSP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != IDLE);
    assign alu_reset     = reset;

endmodule
